// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the RISC datapath storage elements.
//   DATA_W    : architectural word width.
//   REG_RESET : value every general-purpose register takes on reset.
//   word_t    : one architectural word, used by file_register and the
//               register file that replicates it.
// -----------------------------------------------------------------------------
package risc_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    localparam word_t REG_RESET = 16'h0000;

endpackage : risc_pkg

// File: rtl/file_reg_bit.sv
// -----------------------------------------------------------------------------
// file_reg_bit
// Single-bit storage cell with a synchronous load enable and a synchronous,
// active-low reset to a per-bit value.
//   clk    : rising-edge clock.
//   rst_n  : synchronous active-low reset, wins over en.
//   en     : load enable; when high, d is captured on the rising edge.
//   d      : write data bit.
//   q      : stored bit.
// -----------------------------------------------------------------------------
module file_reg_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    // Recirculating mux: with en low the flop reloads itself, so nothing on d
    // (including X) reaches q.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : file_reg_bit

// File: rtl/file_register.sv
// -----------------------------------------------------------------------------
// file_register
// One architectural word of the register file: a WIDTH-bit register with a
// synchronous load enable, plus status derived from the stored word.
//   clk       : rising-edge clock, the only clock.
//   reset     : synchronous active-low reset; beats enable.
//   D         : write data.
//   enable    : active-high load enable.
//   Q         : stored word, presented continuously.
//   q_zero    : Q == 0.
//   q_neg     : Q[WIDTH-1].
//   q_parity  : XOR of all bits of Q.
//   wr_strobe : high for the one cycle following each loading edge; behaves
//               as a valid pulse with no ready (the consumer cannot stall it).
//   written   : sticky, set by the first load since reset.
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module file_register
    import risc_pkg::*;
#(
    parameter int               WIDTH       = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = REG_RESET
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic             enable,
    output logic [WIDTH-1:0] Q,
    output logic             q_zero,
    output logic             q_neg,
    output logic             q_parity,
    output logic             wr_strobe,
    output logic             written
);

    // -------------------------------------------------------------------------
    // Storage: one enabled cell per bit, each with its own reset value.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        file_reg_bit #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_bit (
            .clk   (clk),
            .rst_n (reset),
            .en    (enable),
            .d     (D[i]),
            .q     (Q[i])
        );
    end

    // -------------------------------------------------------------------------
    // Write strobe and sticky written flag.
    // -------------------------------------------------------------------------
    logic wr_strobe_d;
    logic wr_strobe_q;
    logic written_d;
    logic written_q;

    always_comb begin
        wr_strobe_d = enable;
        written_d   = written_q | enable;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_strobe_q <= 1'b0;
            written_q   <= 1'b0;
        end else begin
            wr_strobe_q <= wr_strobe_d;
            written_q   <= written_d;
        end
    end

    assign wr_strobe = wr_strobe_q;
    assign written   = written_q;

    // -------------------------------------------------------------------------
    // Status flags: purely combinational from Q, no path from D.
    // -------------------------------------------------------------------------
    assign q_zero = ~|Q;
    assign q_neg  = Q[WIDTH-1];

    // Parity as an explicit balanced XOR tree. Q is zero-padded up to the next
    // power of two so every level halves cleanly; padding zeros do not change
    // the result.
    localparam int LEVELS = $clog2(WIDTH);
    localparam int LEAVES = 1 << LEVELS;

    logic [LEAVES-1:0] parity_leaf;

    always_comb begin
        parity_leaf             = '0;
        parity_leaf[WIDTH-1:0]  = Q;
    end

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [(LEAVES >> l)-1:0] node;
        if (l == 0) begin : g_leaf
            assign node = parity_leaf;
        end else begin : g_pair
            for (genvar n = 0; n < (LEAVES >> l); n++) begin : g_node
                assign node[n] = g_lvl[l-1].node[2*n] ^ g_lvl[l-1].node[2*n+1];
            end
        end
    end

    assign q_parity = g_lvl[LEVELS].node[0];

endmodule : file_register

// File: tb/tb_file_register.sv
// -----------------------------------------------------------------------------
// tb_file_register
// Drives directed and random traffic into file_register. Each driven edge
// pushes the predicted post-edge outputs into exp_q; a monitor on the falling
// edge pops one entry and compares every output.
// -----------------------------------------------------------------------------
module tb_file_register;
  import risc_pkg::*;

  localparam int W  = DATA_W;
  localparam int EW = W + 5;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic  clk = 1'b0;
  logic  reset;
  logic  enable;
  word_t d;
  word_t q;
  logic  q_zero;
  logic  q_neg;
  logic  q_parity;
  logic  wr_strobe;
  logic  written;

  always #5 clk = ~clk;

  file_register #(
    .WIDTH       (W),
    .RESET_VALUE (REG_RESET)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .D         (d),
    .enable    (enable),
    .Q         (q),
    .q_zero    (q_zero),
    .q_neg     (q_neg),
    .q_parity  (q_parity),
    .wr_strobe (wr_strobe),
    .written   (written)
  );

  // ---------------------------------------------------------------------------
  // Reference model (register semantics, not RTL structure)
  // ---------------------------------------------------------------------------
  word_t m_q       = REG_RESET;
  logic  m_strobe  = 1'b0;
  logic  m_written = 1'b0;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [EW-1:0] predict();
    logic zero_f;
    logic neg_f;
    logic par_f;
    zero_f = (m_q == 16'd0);
    neg_f  = ($signed(m_q) < 0);
    par_f  = ($countones(m_q) % 2) == 1;
    return {m_q, zero_f, neg_f, par_f, m_strobe, m_written};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input logic rst, input logic en, input word_t dv);
    reset  = rst;
    enable = en;
    d      = dv;
    if (!rst) begin
      m_q       = REG_RESET;
      m_strobe  = 1'b0;
      m_written = 1'b0;
    end else if (en) begin
      m_q       = dv;
      m_strobe  = 1'b1;
      m_written = 1'b1;
    end else begin
      m_strobe  = 1'b0;
    end
    exp_q.push_back(predict());
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("Q",         q,                    mon_e[EW-1:5]);
      check("q_zero",    {15'd0, q_zero},      {15'd0, mon_e[4]});
      check("q_neg",     {15'd0, q_neg},       {15'd0, mon_e[3]});
      check("q_parity",  {15'd0, q_parity},    {15'd0, mon_e[2]});
      check("wr_strobe", {15'd0, wr_strobe},   {15'd0, mon_e[1]});
      check("written",   {15'd0, written},     {15'd0, mon_e[0]});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    d      = 16'hFFFF;

    // Reset with a competing write.
    drive(1'b0, 1'b1, 16'hFFFF);
    drive(1'b0, 1'b1, 16'hFFFF);

    // Basic load, then back-to-back loads.
    drive(1'b1, 1'b1, 16'h0001);
    drive(1'b1, 1'b1, 16'h0002);
    drive(1'b1, 1'b1, 16'h8000);

    // Hold while D wanders.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, word_t'($urandom));
    end

    // Reset beats a same-edge write, then first released edge loads.
    drive(1'b0, 1'b1, 16'h1234);
    drive(1'b1, 1'b1, 16'h1234);

    // Same-value write twice, then idle.
    drive(1'b1, 1'b1, 16'h1234);
    drive(1'b1, 1'b1, 16'h1234);
    drive(1'b1, 1'b0, 16'h0000);

    // Corner words.
    drive(1'b1, 1'b1, 16'hFFFF);
    drive(1'b1, 1'b1, 16'h0000);
    drive(1'b1, 1'b1, 16'h7FFF);
    drive(1'b1, 1'b0, 16'hFFFF);

    // Random traffic with occasional resets and repeated values.
    for (int i = 0; i < 400; i++) begin
      logic  r_rst;
      logic  r_en;
      word_t r_d;
      r_rst = ($urandom_range(0, 19) != 0);
      r_en  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       r_d = m_q;
        1:       r_d = 16'h0000;
        2:       r_d = 16'hFFFF;
        default: r_d = word_t'($urandom);
      endcase
      drive(r_rst, r_en, r_d);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_file_register
